call_stack_param: RTL and testbench

- Parameterised hardware return-address stack for the single-cycle processor family; successor to the fixed 12-bit call stack feeding the PC-source mux.
- Generalised in entry width and depth, with two overflow modes: reject, or circular overwrite of the oldest entry.
- Adds occupancy count, full/empty status, sticky overflow/underflow error flags, and same-cycle push+pop, which replaces the top entry (tail-call).
- The top-of-stack output is combinational, so a return instruction can use it as the next PC in the same cycle as its pop.

---
 rtl/call_stack_param.sv | 69 ++++++
 tb/tb_call_stack_param.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/call_stack_param.sv
// call_stack_param: parameterised return-address stack with combinational top-of-stack,
// reject or circular overflow, same-cycle push+pop replace, and sticky error flags.
module call_stack_param #(
    parameter int WIDTH    = 12,
    parameter int DEPTH    = 8,
    parameter int OVF_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp, top_idx, wp_inc;
    logic             do_push, do_pop, do_replace, ovf_ev, unf_ev;

    always_comb begin
        top_idx    = (wp == '0) ? PW'(DEPTH-1) : wp - 1'b1;
        wp_inc     = (wp == PW'(DEPTH-1)) ? '0 : wp + 1'b1;
        empty      = (count == '0);
        full       = (count == CW'(DEPTH));
        top        = empty ? '0 : mem[top_idx];
        do_replace = push & pop & ~empty;
        // push+pop on an empty stack degenerates to a plain push
        do_push    = push & (~pop | empty) & (~full | (OVF_MODE != 0));
        do_pop     = pop & ~push & ~empty;
        ovf_ev     = push & ~pop & full;
        unf_ev     = pop & empty;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_push)
                wp <= wp_inc;
            else if (do_pop)
                wp <= top_idx;
            if (do_push && !full)
                count <= count + CW'(1);
            else if (do_pop)
                count <= count - CW'(1);
            overflow  <= ovf_ev | (overflow & ~clr_err);
            underflow <= unf_ev | (underflow & ~clr_err);
        end
    end

    // storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (do_replace)
            mem[top_idx] <= push_data;
        else if (do_push)
            mem[wp] <= push_data;
    end
endmodule

// File: tb/tb_call_stack_param.sv
// tb_call_stack_param: drives a reject-mode and a circular-mode stack with shared stimulus
// and checks both against an array-based reference model.
module tb_call_stack_param;
    localparam int W = 12;
    localparam int D = 4;

    logic         clk = 0, rst = 0, push = 0, pop = 0, clr_err = 0;
    logic [W-1:0] push_data = '0;
    logic [W-1:0] top_a, top_b;
    logic [2:0]   count_a, count_b;
    logic         empty_a, empty_b, full_a, full_b, ovf_a, ovf_b, unf_a, unf_b;

    int npass = 0, ntot = 0;

    logic [W-1:0] ms [2][D];
    int           mc [2];
    bit           mo [2], mu [2];

    call_stack_param #(.WIDTH(W), .DEPTH(D), .OVF_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data), .clr_err(clr_err),
        .top(top_a), .count(count_a), .empty(empty_a), .full(full_a),
        .overflow(ovf_a), .underflow(unf_a));

    call_stack_param #(.WIDTH(W), .DEPTH(D), .OVF_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data), .clr_err(clr_err),
        .top(top_b), .count(count_b), .empty(empty_b), .full(full_b),
        .overflow(ovf_b), .underflow(unf_b));

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mtop(input int m);
        return (mc[m] > 0) ? ms[m][mc[m]-1] : '0;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mc[m] = 0; mo[m] = 0; mu[m] = 0;
        end
    endtask

    task automatic model_step(input bit p, input bit o, input logic [W-1:0] d, input bit c);
        for (int m = 0; m < 2; m++) begin
            if (c) begin mo[m] = 0; mu[m] = 0; end
            if (p && o) begin
                if (mc[m] == 0) begin ms[m][0] = d; mc[m] = 1; mu[m] = 1; end
                else ms[m][mc[m]-1] = d;
            end else if (p) begin
                if (mc[m] < D) begin ms[m][mc[m]] = d; mc[m]++; end
                else begin
                    mo[m] = 1;
                    if (m == 1) begin
                        for (int i = 0; i < D-1; i++) ms[m][i] = ms[m][i+1];
                        ms[m][D-1] = d;
                    end
                end
            end else if (o) begin
                if (mc[m] > 0) mc[m]--;
                else mu[m] = 1;
            end
        end
    endtask

    task automatic cyc(input bit p, input bit o, input logic [W-1:0] d, input bit c);
        @(negedge clk);
        push = p; pop = o; push_data = d; clr_err = c;
        @(posedge clk);
        model_step(p, o, d, c);
        #1;
        push = 0; pop = 0; clr_err = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < D + 1 && (mc[0] > 0 || mc[1] > 0); i++) cyc(0, 1, '0, 0);
        cyc(0, 0, '0, 1);
    endtask

    task automatic test_reset();
        ntot++; if (top_a !== 12'h000) $display("FAIL reset_top got=%h exp=000", top_a); else npass++;
        ntot++; if (count_a !== 3'd0 || count_b !== 3'd0) $display("FAIL reset_count got=%0d/%0d exp=0", count_a, count_b); else npass++;
        ntot++; if ({empty_a, full_a, ovf_a, unf_a} !== 4'b1000) $display("FAIL reset_status got=%b exp=1000", {empty_a, full_a, ovf_a, unf_a}); else npass++;
    endtask

    task automatic test_basic();
        logic [W-1:0] exp_pop [3] = '{12'h202, 12'h101, 12'h000};
        cyc(1, 0, 12'h101, 0); cyc(1, 0, 12'h202, 0); cyc(1, 0, 12'h303, 0);
        ntot++; if (top_a !== 12'h303) $display("FAIL basic_top got=%h exp=303", top_a); else npass++;
        ntot++; if (count_a !== 3'd3) $display("FAIL basic_count got=%0d exp=3", count_a); else npass++;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, '0, 0);
            ntot++; if (top_a !== exp_pop[i]) $display("FAIL basic_pop%0d got=%h exp=%h", i, top_a, exp_pop[i]); else npass++;
        end
        ntot++; if (empty_a !== 1'b1) $display("FAIL basic_empty got=%b exp=1", empty_a); else npass++;
    endtask

    task automatic test_overflow_modes();
        for (int i = 1; i <= 4; i++) cyc(1, 0, 12'h0A0 + 12'(i), 0);
        ntot++; if (full_a !== 1'b1 || full_b !== 1'b1) $display("FAIL ovf_full got=%b%b exp=11", full_a, full_b); else npass++;
        cyc(1, 0, 12'h0A5, 0);
        ntot++; if (ovf_a !== 1'b1 || top_a !== 12'h0A4 || count_a !== 3'd4) $display("FAIL reject_push got=ovf%b top%h cnt%0d exp=ovf1 top0a4 cnt4", ovf_a, top_a, count_a); else npass++;
        cyc(1, 0, 12'h0A6, 0);
        ntot++; if (ovf_b !== 1'b1 || top_b !== 12'h0A6 || count_b !== 3'd4) $display("FAIL circ_push got=ovf%b top%h cnt%0d exp=ovf1 top0a6 cnt4", ovf_b, top_b, count_b); else npass++;
        for (int i = 0; i < 4; i++) begin
            ntot++; if (top_a !== 12'h0A4 - 12'(i)) $display("FAIL reject_pop%0d got=%h exp=%h", i, top_a, 12'h0A4 - 12'(i)); else npass++;
            ntot++; if (top_b !== 12'h0A6 - 12'(i)) $display("FAIL circ_pop%0d got=%h exp=%h", i, top_b, 12'h0A6 - 12'(i)); else npass++;
            cyc(0, 1, '0, 0);
        end
        ntot++; if (empty_a !== 1'b1 || empty_b !== 1'b1) $display("FAIL ovf_drained got=%b%b exp=11", empty_a, empty_b); else npass++;
        cyc(0, 0, '0, 1);
        model_reset();
    endtask

    task automatic test_replace();
        cyc(1, 0, 12'h010, 0); cyc(1, 0, 12'h020, 0); cyc(1, 1, 12'h0FF, 0);
        ntot++; if (count_a !== 3'd2 || top_a !== 12'h0FF) $display("FAIL replace got=cnt%0d top%h exp=cnt2 top0ff", count_a, top_a); else npass++;
        cyc(0, 1, '0, 0);
        ntot++; if (top_a !== 12'h010) $display("FAIL replace_pop got=%h exp=010", top_a); else npass++;
        cyc(1, 0, 12'h030, 0); cyc(1, 0, 12'h040, 0); cyc(1, 0, 12'h050, 0); cyc(1, 1, 12'h077, 0);
        ntot++; if (full_a !== 1'b1 || ovf_a !== 1'b0 || ovf_b !== 1'b0 || top_a !== 12'h077) $display("FAIL replace_full got=full%b ovf%b%b top%h exp=full1 ovf00 top077", full_a, ovf_a, ovf_b, top_a); else npass++;
        drain();
    endtask

    task automatic test_underflow();
        cyc(0, 1, '0, 0);
        ntot++; if (unf_a !== 1'b1 || count_a !== 3'd0 || top_a !== 12'h000) $display("FAIL unf_set got=unf%b cnt%0d top%h exp=unf1 cnt0 top000", unf_a, count_a, top_a); else npass++;
        cyc(0, 0, '0, 1);
        ntot++; if (unf_a !== 1'b0) $display("FAIL unf_clear got=%b exp=0", unf_a); else npass++;
        cyc(0, 1, '0, 1);
        ntot++; if (unf_a !== 1'b1) $display("FAIL unf_setwins got=%b exp=1", unf_a); else npass++;
        cyc(1, 1, 12'h055, 0);
        ntot++; if (count_a !== 3'd1 || top_a !== 12'h055 || unf_a !== 1'b1) $display("FAIL unf_pushpop got=cnt%0d top%h unf%b exp=cnt1 top055 unf1", count_a, top_a, unf_a); else npass++;
        drain();
    endtask

    task automatic test_async_reset();
        cyc(1, 0, 12'h111, 0); cyc(1, 0, 12'h222, 0); cyc(1, 0, 12'h333, 0); cyc(0, 1, '0, 0); cyc(0, 1, '0, 0); cyc(0, 1, '0, 0); cyc(0, 1, '0, 0);
        cyc(1, 0, 12'h444, 0); cyc(1, 0, 12'h555, 0); cyc(1, 0, 12'h666, 0);
        ntot++; if (count_a !== 3'd3 || unf_a !== 1'b1) $display("FAIL arst_pre got=cnt%0d unf%b exp=cnt3 unf1", count_a, unf_a); else npass++;
        #2 rst = 0;
        #1;
        ntot++; if (count_a !== 3'd0 || empty_a !== 1'b1 || top_a !== 12'h000 || unf_a !== 1'b0 || count_b !== 3'd0) $display("FAIL arst_now got=cnt%0d empty%b top%h unf%b exp=cnt0 empty1 top000 unf0", count_a, empty_a, top_a, unf_a); else npass++;
        model_reset();
        #1 rst = 1;
        cyc(1, 0, 12'h123, 0);
        ntot++; if (top_a !== 12'h123 || top_b !== 12'h123) $display("FAIL arst_after got=%h/%h exp=123", top_a, top_b); else npass++;
        drain();
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 2) == 0), W'($urandom), bit'($urandom_range(0, 9) == 0));
            ntot++; if (top_a !== mtop(0) || count_a !== 3'(mc[0])) $display("FAIL rand_a_data n=%0d got=top%h cnt%0d exp=top%h cnt%0d", n, top_a, count_a, mtop(0), mc[0]); else npass++;
            ntot++; if (top_b !== mtop(1) || count_b !== 3'(mc[1])) $display("FAIL rand_b_data n=%0d got=top%h cnt%0d exp=top%h cnt%0d", n, top_b, count_b, mtop(1), mc[1]); else npass++;
            ntot++; if ({empty_a, full_a, ovf_a, unf_a} !== {mc[0] == 0, mc[0] == D, mo[0], mu[0]}) $display("FAIL rand_a_flags n=%0d got=%b exp=%b", n, {empty_a, full_a, ovf_a, unf_a}, {mc[0] == 0, mc[0] == D, mo[0], mu[0]}); else npass++;
            ntot++; if ({empty_b, full_b, ovf_b, unf_b} !== {mc[1] == 0, mc[1] == D, mo[1], mu[1]}) $display("FAIL rand_b_flags n=%0d got=%b exp=%b", n, {empty_b, full_b, ovf_b, unf_b}, {mc[1] == 0, mc[1] == D, mo[1], mu[1]}); else npass++;
        end
    endtask

    initial begin
        model_reset();
        #12;
        test_reset();
        #1 rst = 1;
        test_basic();
        test_overflow_modes();
        test_replace();
        test_underflow();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
